// File: rtl/alu_operand_stage_pkg.sv
// Shared core definitions for the ALU operand stage: default operand width
// and the conventional source slot assignments on the packed source bus.
package alu_operand_stage_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam int unsigned SRC_REG2    = 0;
  localparam int unsigned SRC_IMM     = 1;
  localparam int unsigned SRC_FWD_MEM = 2;
  localparam int unsigned SRC_FWD_WB  = 3;

endpackage

// File: rtl/alu_operand_stage_src_mux.sv
// NSRC:1 operand select; an index outside the populated sources yields an
// all-zero operand and raises oor so the stage can record the error.
module operand_src_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  oor
);

  // NOTE: every output gets a default before the loop; otherwise an
  // unmatched index leaves it unassigned and a latch is inferred.
  always_comb begin
    data = '0;
    oor  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SEL_W'(k)) begin
        data = src_data[k*WIDTH +: WIDTH];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand selection for both ALU inputs, registered into a one-deep pipeline
// stage with a valid/ready handshake and a single-entry skid buffer.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NSRC  = 4,
  parameter  int CNT_W = 8,
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]      sel_a,
  input  logic [SEL_W-1:0]      sel_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic                  sel_err,
  output logic [CNT_W-1:0]      xfer_cnt
);

  logic [WIDTH-1:0] mux_a, mux_b;
  logic             oor_a, oor_b;

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_a, main_b, skid_a, skid_b;
  logic             accept, emit;

  operand_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) u_mux_a (
    .src_data (src_data),
    .sel      (sel_a),
    .data     (mux_a),
    .oor      (oor_a)
  );

  operand_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) u_mux_b (
    .src_data (src_data),
    .sel      (sel_b),
    .data     (mux_b),
    .oor      (oor_b)
  );

  // Ready depends only on the skid flag, so out_ready never reaches in_ready.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready & ~flush;
  assign emit      = main_valid & out_ready;

  assign out_valid = main_valid;
  assign op_a      = main_a;
  assign op_b      = main_b;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_a     <= '0;
      main_b     <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
      sel_err    <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      if (accept) begin
        xfer_cnt <= xfer_cnt + 1'b1;
        if (oor_a | oor_b) sel_err <= 1'b1;
      end

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || emit) begin
        // Main slot frees up: the older skid entry always goes first. An
        // accept cannot coincide with a full skid because in_ready is low.
        if (skid_valid) begin
          main_a     <= skid_a;
          main_b     <= skid_b;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_a     <= mux_a;
          main_b     <= mux_b;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_a     <= mux_a;
        skid_b     <= mux_b;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule
